caesar_stream_cipher: RTL and testbench

Streaming, pipelined successor to the single-character shift cipher. It applies a Vigenère-style key sequence of up to KEY_DEPTH shift values to a byte stream under valid/ready flow control. Digits, uppercase and lowercase letters are shifted with wrap-around inside their own range; all other bytes pass through unchanged and do not consume a key position. It sits between the character source (UART/keypad front end) and the alphanumeric display driver.

---
 rtl/cipher_pkg.sv | 42 ++++
 rtl/cipher_char_shift.sv | 67 ++++++
 rtl/caesar_stream_cipher.sv | 189 ++++++++++++++++++
 tb/tb_caesar_stream_cipher.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared constants, class/state enums and key-residue helpers for caesar_stream_cipher.
package cipher_pkg;

    localparam logic [7:0] DIG_LO = 8'd48;
    localparam logic [7:0] DIG_HI = 8'd57;
    localparam logic [7:0] UP_LO  = 8'd65;
    localparam logic [7:0] UP_HI  = 8'd90;
    localparam logic [7:0] LO_LO  = 8'd97;
    localparam logic [7:0] LO_HI  = 8'd122;

    localparam logic [7:0] DIG_RANGE   = 8'd10;
    localparam logic [7:0] ALPHA_RANGE = 8'd26;

    typedef enum logic [1:0] {
        CLS_DIGIT,
        CLS_UPPER,
        CLS_LOWER,
        CLS_OTHER
    } cls_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN
    } state_e;

    function automatic cls_e classify(input logic [7:0] b);
        if (b >= DIG_LO && b <= DIG_HI) return CLS_DIGIT;
        if (b >= UP_LO  && b <= UP_HI)  return CLS_UPPER;
        if (b >= LO_LO  && b <= LO_HI)  return CLS_LOWER;
        return CLS_OTHER;
    endfunction

    function automatic logic [4:0] mod26(input logic [7:0] v);
        return 5'(v % ALPHA_RANGE);
    endfunction

    function automatic logic [3:0] mod10(input logic [7:0] v);
        return 4'(v % DIG_RANGE);
    endfunction

endpackage

// File: rtl/cipher_char_shift.sv
// Combinational in-range shift of one classified byte; the decrypt path exists
// only when CIPHER_DECRYPT_EN is defined.
module cipher_char_shift
    import cipher_pkg::*;
(
    input  logic [7:0] data_i,
    input  cls_e       cls_i,
    input  logic [4:0] r26_i,
    input  logic [3:0] r10_i,
`ifdef CIPHER_DECRYPT_EN
    input  logic       dec_i,
`endif
    output logic [7:0] data_o
);

    logic [8:0] top, size, shift, sum, enc, res;
    logic       res_unused;
`ifdef CIPHER_DECRYPT_EN
    logic [8:0] base, diff, dec;
`endif

    always_comb begin
        top   = {1'b0, LO_HI};
        size  = {1'b0, ALPHA_RANGE};
        shift = {4'b0, r26_i};
`ifdef CIPHER_DECRYPT_EN
        base  = {1'b0, LO_LO};
`endif
        case (cls_i)
            CLS_DIGIT: begin
                top   = {1'b0, DIG_HI};
                size  = {1'b0, DIG_RANGE};
                shift = {5'b0, r10_i};
`ifdef CIPHER_DECRYPT_EN
                base  = {1'b0, DIG_LO};
`endif
            end
            CLS_UPPER: begin
                top   = {1'b0, UP_HI};
`ifdef CIPHER_DECRYPT_EN
                base  = {1'b0, UP_LO};
`endif
            end
            default: ;
        endcase

        // Residues are below the range size, so one conditional correction suffices.
        sum = {1'b0, data_i} + shift;
        enc = (sum > top) ? sum - size : sum;
`ifdef CIPHER_DECRYPT_EN
        diff = {1'b0, data_i} - shift;
        dec  = (diff < base) ? diff + size : diff;
`endif

        res = {1'b0, data_i};
        if (cls_i != CLS_OTHER) begin
            res = enc;
`ifdef CIPHER_DECRYPT_EN
            if (dec_i) res = dec;
`endif
        end
    end

    assign data_o     = res[7:0];
    assign res_unused = res[8];

endmodule

// File: rtl/caesar_stream_cipher.sv
// Two-stage streaming Vigenere-style shift cipher with a KEY_DEPTH-slot residue key.
// Decrypt support is built only when CIPHER_DECRYPT_EN is defined.
module caesar_stream_cipher
    import cipher_pkg::*;
#(
    parameter int  KEY_DEPTH = 16,
    localparam int KAW       = $clog2(KEY_DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           key_we,
    input  logic [KAW-1:0] key_waddr,
    input  logic [7:0]     key_wdata,
    input  logic [KAW:0]   key_len,
    input  logic           mode,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_data,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     out_data,
    output logic           out_last,
    output logic           busy,
    output logic           key_err
);

    localparam logic [KAW:0] LEN_MAX = (KAW+1)'(KEY_DEPTH);
    localparam logic [KAW:0] LEN_ONE = (KAW+1)'(1);

    state_e         state_q, state_d;
    logic [4:0]     key26_q [KEY_DEPTH];
    logic [3:0]     key10_q [KEY_DEPTH];
    logic [KAW:0]   len_q;
    logic [KAW-1:0] idx_q, idx_d;
    logic           key_err_q;

    logic           s1_valid_q, s1_last_q;
    logic [7:0]     s1_data_q;
    cls_e           s1_cls_q;
    logic [4:0]     s1_r26_q;
    logic [3:0]     s1_r10_q;
    logic           s2_valid_q, s2_last_q;
    logic [7:0]     s2_data_q;

    logic           s1_ready, s2_ready, acc, start, use_key;
    logic [KAW:0]   len_in, eff_len, idx_inc;
    logic [KAW-1:0] eff_idx;
    cls_e           in_cls;
    logic [4:0]     r26;
    logic [3:0]     r10;
    logic [7:0]     shifted;

`ifdef CIPHER_DECRYPT_EN
    logic           mode_q, s1_dec_q, eff_dec;
`else
    logic           mode_unused;
    assign mode_unused = mode;
`endif

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and payload is held while valid && !ready.
    // A stage loads when it is empty or its downstream stage takes its content.
    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = rst_n && !key_we && (state_q != ST_DRAIN) && s1_ready;
    assign acc      = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE) || s1_valid_q || s2_valid_q;

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_last  = s2_last_q;
    assign key_err   = key_err_q;

    always_comb begin
        start   = (state_q == ST_IDLE);
        len_in  = (key_len > LEN_MAX) ? LEN_MAX : key_len;
        eff_len = start ? len_in : len_q;
        eff_idx = start ? '0 : idx_q;
        in_cls  = classify(in_data);
        use_key = (in_cls != CLS_OTHER) && (eff_len != '0);
        r26     = use_key ? key26_q[eff_idx] : '0;
        r10     = use_key ? key10_q[eff_idx] : '0;
        idx_inc = {1'b0, eff_idx} + LEN_ONE;
`ifdef CIPHER_DECRYPT_EN
        eff_dec = start ? mode : mode_q;
`endif

        idx_d = idx_q;
        if (acc) begin
            idx_d = eff_idx;
            if (use_key) idx_d = (idx_inc == eff_len) ? '0 : idx_inc[KAW-1:0];
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACTIVE: if (acc) state_d = in_last ? ST_DRAIN : ST_ACTIVE;
            ST_DRAIN:           if (!s1_valid_q && !s2_valid_q) state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    // Residues are reduced at write time so the data path never divides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_err_q <= 1'b0;
            for (int i = 0; i < KEY_DEPTH; i++) begin
                key26_q[i] <= '0;
                key10_q[i] <= '0;
            end
        end else begin
            key_err_q <= key_we && busy;
            if (key_we && !busy) begin
                key26_q[key_waddr] <= mod26(key_wdata);
                key10_q[key_waddr] <= mod10(key_wdata);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
`ifdef CIPHER_DECRYPT_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (acc && start) begin
                len_q  <= len_in;
`ifdef CIPHER_DECRYPT_EN
                mode_q <= mode;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_cls_q   <= CLS_OTHER;
            s1_r26_q   <= '0;
            s1_r10_q   <= '0;
`ifdef CIPHER_DECRYPT_EN
            s1_dec_q   <= 1'b0;
`endif
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= shifted;
                    s2_last_q <= s1_last_q;
                end
            end
            if (s1_ready) begin
                s1_valid_q <= acc;
                if (acc) begin
                    s1_data_q <= in_data;
                    s1_cls_q  <= in_cls;
                    s1_r26_q  <= r26;
                    s1_r10_q  <= r10;
                    s1_last_q <= in_last;
`ifdef CIPHER_DECRYPT_EN
                    s1_dec_q  <= eff_dec;
`endif
                end
            end
        end
    end

    cipher_char_shift u_shift (
        .data_i (s1_data_q),
        .cls_i  (s1_cls_q),
        .r26_i  (s1_r26_q),
        .r10_i  (s1_r10_q),
`ifdef CIPHER_DECRYPT_EN
        .dec_i  (s1_dec_q),
`endif
        .data_o (shifted)
    );

endmodule

// File: tb/tb_caesar_stream_cipher.sv
// Directed-vector bench for caesar_stream_cipher with an in-order output scoreboard.
module tb_caesar_stream_cipher;

  localparam int KEY_DEPTH = 16;
  localparam int KAW       = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           key_we = 1'b0;
  logic [KAW-1:0] key_waddr = '0;
  logic [7:0]     key_wdata = '0;
  logic [KAW:0]   key_len = '0;
  logic           mode = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     in_data = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [7:0]     out_data;
  logic           out_last;
  logic           busy;
  logic           key_err;

  int             n_cmp = 0;
  int             n_err = 0;
  int             bp_acc = 0;
  logic [8:0]     exp_q[$];
  logic [8:0]     hold_val = '0;
  logic           hold_v = 1'b0;

  caesar_stream_cipher #(.KEY_DEPTH(KEY_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_we    (key_we),
    .key_waddr (key_waddr),
    .key_wdata (key_wdata),
    .key_len   (key_len),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .key_err   (key_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: outputs sampled on the falling edge, popped on each transfer
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (hold_v) check("stall_hold", {23'b0, out_last, out_data}, {23'b0, hold_val});
      if (out_ready) begin
        if (exp_q.size() == 0) check("exp_empty", exp_q.size(), 1);
        else check("out_byte", {23'b0, out_last, out_data}, {23'b0, exp_q.pop_front()});
        hold_v = 1'b0;
      end else begin
        hold_val = {out_last, out_data};
        hold_v   = 1'b1;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // drivers: inputs change 1ns after the rising edge
  task automatic send_byte(input logic [7:0] b, input logic last);
    int   guard = 0;
    logic took  = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!took && guard < 200) begin
      @(negedge clk);
      took = in_ready;
      guard++;
      @(posedge clk);
      #1;
    end
    if (!took) check("accept_timeout", {31'b0, took}, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input string e, input logic end_msg);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({end_msg && (i == s.len() - 1), e[i]});
    for (int i = 0; i < s.len(); i++) send_byte(s[i], end_msg && (i == s.len() - 1));
  endtask

  task automatic write_key(input logic [KAW-1:0] a, input logic [7:0] v);
    key_we    = 1'b1;
    key_waddr = a;
    key_wdata = v;
    @(posedge clk);
    #1;
    key_we = 1'b0;
  endtask

  task automatic wait_idle;
    int guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_timeout", {31'b0, busy}, 0);
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {24'b0, out_data}, 0);
    check("rst_out_last", {31'b0, out_last}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_key_err", {31'b0, key_err}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // key {3}: latency then "Az9!" -> "Dc2!"
    write_key(0, 8'd3);
    @(negedge clk);
    check("key_err_idle", {31'b0, key_err}, 0);
    @(posedge clk);
    #1;
    key_len = 1;
    exp_q.push_back({1'b1, 8'h44});
    send_byte(8'h41, 1'b1);
    @(negedge clk);
    check("lat_1", {31'b0, out_valid}, 0);
    @(negedge clk);
    check("lat_2", {31'b0, out_valid}, 1);
    wait_idle();
    send_str("Az9!", "Dc2!", 1'b1);
    wait_idle();

    // key {1,2}: non-alnum passes and does not advance, idx wraps
    write_key(0, 8'd1);
    write_key(1, 8'd2);
    key_len = 2;
    send_str("a ba", "b db", 1'b1);
    wait_idle();

    // residues of raw key values
    write_key(0, 8'd29);
    key_len = 1;
    send_str("A0", "D9", 1'b1);
    wait_idle();
    write_key(0, 8'd255);
    send_str("a", "v", 1'b1);
    wait_idle();

    // decrypt request
    write_key(0, 8'd3);
    mode = 1'b1;
`ifdef CIPHER_DECRYPT_EN
    send_str("a0A", "x7X", 1'b1);
`else
    send_str("a0A", "d3D", 1'b1);
`endif
    wait_idle();
    mode = 1'b0;

    // backpressure with passthrough key
    key_len   = 0;
    out_ready = 1'b0;
    fork
      send_str("Hello!", "Hello!", 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          if (in_valid && in_ready) bp_acc++;
        end
        check("bp_accepts", bp_acc, 2);
        check("bp_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // key write while a message is open is rejected
    key_len = 1;
    write_key(0, 8'd3);
    send_str("a", "d", 1'b0);
    key_we    = 1'b1;
    key_waddr = 0;
    key_wdata = 8'd7;
    @(negedge clk);
    check("kw_in_ready", {31'b0, in_ready}, 0);
    check("kw_busy", {31'b0, busy}, 1);
    @(posedge clk);
    #1;
    key_we = 1'b0;
    @(negedge clk);
    check("key_err_pulse", {31'b0, key_err}, 1);
    @(negedge clk);
    check("key_err_clear", {31'b0, key_err}, 0);
    @(posedge clk);
    #1;
    send_str("b", "e", 1'b1);
    wait_idle();
    send_str("c", "f", 1'b1);
    wait_idle();

    // reset mid-message
    write_key(0, 8'd1);
    write_key(1, 8'd2);
    key_len   = 2;
    out_ready = 1'b0;
    send_byte(8'h61, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_str("ab", "ab", 1'b1);
    wait_idle();
    write_key(0, 8'd1);
    write_key(1, 8'd2);
    send_str("aa", "bc", 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
